// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer: ALU opcodes and FSM states.
package alu_mul_sequencer_pkg;

    localparam logic [4:0] ALU_OP_ADD = 5'b00000;
    localparam logic [4:0] ALU_OP_SUB = 5'b00010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller driving the shared ALU's ADD path.
// It iterates only over the significant bits of the multiplier.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_ovf,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_cin,
    output logic [4:0]   alu_op,
    input  logic [W-1:0] alu_result,
    input  logic         alu_c
);

    state_t       state, state_nx;
    logic [W-1:0] p_q, p_nx;
    logic [W-1:0] m_q, m_nx;
    logic [W-1:0] q_q, q_nx;
    logic [W-1:0] q_rest;
    logic         ovf_q, ovf_nx;
    logic [W-1:0] prod_q, prod_nx;
    logic         z_q, z_nx;
    logic         fovf_q, fovf_nx;

    assign q_rest = q_q >> 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            p_q    <= '0;
            m_q    <= '0;
            q_q    <= '0;
            ovf_q  <= 1'b0;
            prod_q <= '0;
            z_q    <= 1'b0;
            fovf_q <= 1'b0;
        end else begin
            state  <= state_nx;
            p_q    <= p_nx;
            m_q    <= m_nx;
            q_q    <= q_nx;
            ovf_q  <= ovf_nx;
            prod_q <= prod_nx;
            z_q    <= z_nx;
            fovf_q <= fovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        p_nx     = p_q;
        m_nx     = m_q;
        q_nx     = q_q;
        ovf_nx   = ovf_q;
        prod_nx  = prod_q;
        z_nx     = z_q;
        fovf_nx  = fovf_q;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    p_nx   = '0;
                    m_nx   = op_a;
                    q_nx   = op_b;
                    ovf_nx = 1'b0;
                    if (op_b != '0) begin
                        state_nx = ST_RUN;
                    end else begin
                        state_nx = ST_DONE;
                        prod_nx  = '0;
                        z_nx     = 1'b1;
                        fovf_nx  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                alu_a = p_q;
                alu_b = m_q;
                if (q_q[0]) begin
                    p_nx   = alu_result;
                    ovf_nx = ovf_q | alu_c;
                end
                // A multiplicand bit shifted out while multiplier bits remain always overflows.
                if (m_q[W-1] && (q_rest != '0)) begin
                    ovf_nx = 1'b1;
                end
                m_nx = m_q << 1;
                q_nx = q_rest;
                if (q_rest == '0) begin
                    state_nx = ST_DONE;
                    prod_nx  = p_nx;
                    z_nx     = (p_nx == '0);
                    fovf_nx  = ovf_nx;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign product  = prod_q;
    assign flag_n   = prod_q[W-1];
    assign flag_z   = z_q;
    assign flag_ovf = fovf_q;
    assign alu_cin  = 1'b0;
    assign alu_op   = ALU_OP_ADD;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: behavioural multiply model plus directed literal cases and random traffic.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done, flag_n, flag_z, flag_ovf, alu_cin, alu_c;
    logic [31:0] product, alu_a, alu_b, alu_result;
    logic [4:0]  alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.W(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product), .flag_n(flag_n),
        .flag_z(flag_z), .flag_ovf(flag_ovf), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_op(alu_op), .alu_result(alu_result), .alu_c(alu_c)
    );

    // Environment ALU: plain 32-bit adder with carry-out.
    assign {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bitlen(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    // Behavioural model: operation in flight, cycles left before the done cycle, published result.
    logic        m_active = 1'b0;
    int          m_left = 0;
    int          m_len = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [31:0] m_prod = '0, pend_prod = '0;
    logic        m_n = 1'b0, m_z = 1'b0, m_ovf = 1'b0, pend_ovf = 1'b0;

    task automatic publish();
        m_prod = pend_prod;
        m_n    = pend_prod[31];
        m_z    = (pend_prod == 32'd0);
        m_ovf  = pend_ovf;
    endtask

    always @(posedge clk or negedge reset_n) begin
        logic [63:0] full;
        if (!reset_n) begin
            m_active = 1'b0; m_left = 0; m_len = 0;
            m_prod = '0; m_n = 1'b0; m_z = 1'b0; m_ovf = 1'b0;
        end else if (m_active) begin
            if (m_left == 0) m_active = 1'b0;
            else begin
                m_left--;
                if (m_left == 0) publish();
            end
        end else if (start) begin
            full      = {32'd0, op_a} * {32'd0, op_b};
            pend_prod = full[31:0];
            pend_ovf  = (full[63:32] != 32'd0);
            m_a = op_a; m_b = op_b;
            m_len = bitlen(op_b);
            m_left = m_len;
            m_active = 1'b1;
            if (m_left == 0) publish();
        end
    end

    // Compare process: every output checked on every falling edge.
    always @(negedge clk) begin
        logic [63:0] mask, part;
        int i;
        chk("busy", {63'd0, busy}, {63'd0, m_active});
        chk("done", {63'd0, done}, {63'd0, (m_active && m_left == 0)});
        chk("product", {32'd0, product}, {32'd0, m_prod});
        chk("flag_n", {63'd0, flag_n}, {63'd0, m_n});
        chk("flag_z", {63'd0, flag_z}, {63'd0, m_z});
        chk("flag_ovf", {63'd0, flag_ovf}, {63'd0, m_ovf});
        chk("alu_cin", {63'd0, alu_cin}, 64'd0);
        chk("alu_op", {59'd0, alu_op}, 64'd0);
        if (m_active && m_left > 0) begin
            i    = m_len - m_left;
            mask = (64'd1 << i) - 64'd1;
            part = {32'd0, m_a} * ({32'd0, m_b} & mask);
            chk("alu_a_run", {32'd0, alu_a}, {32'd0, part[31:0]});
            part = {32'd0, m_a} << i;
            chk("alu_b_run", {32'd0, alu_b}, {32'd0, part[31:0]});
        end else begin
            chk("alu_a_idle", {32'd0, alu_a}, 64'd0);
            chk("alu_b_idle", {32'd0, alu_b}, 64'd0);
        end
    end

    // Directed op with literal expectations; poke>0 re-pulses start (with junk operands) mid-run.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e_prod,
                          input logic e_n, input logic e_z, input logic e_ovf,
                          input int e_lat, input int poke);
        int lat = 0;
        logic got = 1'b0;
        op_a = a; op_b = b; start = 1'b1;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (poke > 0 && lat == poke) begin op_a = 32'd99; op_b = 32'd3; start = 1'b1; end
            if (poke > 0 && lat == poke + 1) start = 1'b0;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", {63'd0, got}, 64'd1);
        chk("latency", lat, e_lat);
        chk("lit_product", {32'd0, product}, {32'd0, e_prod});
        chk("lit_n", {63'd0, flag_n}, {63'd0, e_n});
        chk("lit_z", {63'd0, flag_z}, {63'd0, e_z});
        chk("lit_ovf", {63'd0, flag_ovf}, {63'd0, e_ovf});
        @(posedge clk); #1;
        chk("idle_after", {63'd0, busy}, 64'd0);
        chk("held_product", {32'd0, product}, {32'd0, e_prod});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_product", {32'd0, product}, 64'd0);
        chk("rst_z", {63'd0, flag_z}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 1'b0, 4, 0);
        run_op(32'h1234, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1, 0);
        run_op(32'd0, 32'h1234, 32'd0, 1'b0, 1'b1, 1'b0, 14, 0);
        run_op(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b1, 4, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 33, 0);
        run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 1'b1, 18, 0);
        run_op(32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 1'b0, 4, 2);

        // Reset in the middle of a long run.
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_product", {32'd0, product}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 1'b0, 4, 0);

        // Random traffic, including starts while busy and zero multipliers.
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 3) == 0);
            op_a  = $urandom;
            op_b  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) op_b = 32'd0;
            if ($urandom_range(0, 5) == 0) op_a = 32'hFFFF_FFFF >> $urandom_range(0, 31);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("drained", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
